// File: rtl/sid_pipe_sched_pkg.sv
// Shared types and constants for the SID pipeline scheduler.
package sid_pipe_sched_pkg;

  localparam int unsigned MAX_SIDS           = 4;
  localparam int unsigned VOICE_LAT_DEFAULT  = 1;
  localparam int unsigned FILTER_LAT_DEFAULT = 8;

  // SID index at its widest (up to MAX_SIDS cores); narrowed per instance.
  typedef logic [1:0] sched_sid_t;
  typedef logic [1:0] voice_no_t;

  typedef enum logic {F_IDLE, F_RUN} filt_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic sched_sid_t lowest_set(input logic [MAX_SIDS-1:0] mask);
    sched_sid_t r;
    r = '0;
    for (int unsigned i = MAX_SIDS; i > 0; i--) begin
      if (mask[i-1]) r = sched_sid_t'(i - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sid_pipe_sched_if.sv
// Control/strobe bundle between the scheduler and the voice/filter pipelines.
interface sid_pipe_sched_if #(
  parameter int unsigned NUM_SIDS   = 2,
  parameter int unsigned FILTER_LAT = 8
);
  import sid_pipe_sched_pkg::*;

  localparam int unsigned SW  = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1;
  localparam int unsigned FSW = $clog2(FILTER_LAT);

  logic                start;
  logic                clr_overrun;
  logic                voice_issue;
  logic [SW-1:0]       voice_sid;
  voice_no_t           voice_no;
  logic                vout_valid;
  logic [SW-1:0]       vout_sid;
  voice_no_t           vout_no;
  logic [NUM_SIDS-1:0] osc3_we;
  logic                filter_start;
  logic [SW-1:0]       filter_sid;
  logic [FSW-1:0]      filter_stage;
  logic                filter_wb;
  logic [SW-1:0]       wb_sid;
  logic                audio_valid;
  logic                busy;
  logic                overrun;

  modport master (
    input  start, clr_overrun,
    output voice_issue, voice_sid, voice_no, vout_valid, vout_sid, vout_no,
           osc3_we, filter_start, filter_sid, filter_stage, filter_wb, wb_sid,
           audio_valid, busy, overrun
  );

  modport slave (
    output start, clr_overrun,
    input  voice_issue, voice_sid, voice_no, vout_valid, vout_sid, vout_no,
           osc3_we, filter_start, filter_sid, filter_stage, filter_wb, wb_sid,
           audio_valid, busy, overrun
  );

endinterface

// File: rtl/sid_pipe_sched_filter_seq.sv
// Filter pass sequencer: queues per-SID requests and runs one pass at a time.
module sid_filter_seq
  import sid_pipe_sched_pkg::*;
#(
  parameter int unsigned NUM_SIDS   = 2,
  parameter int unsigned FILTER_LAT = FILTER_LAT_DEFAULT,
  parameter int unsigned SW         = 1,
  parameter int unsigned FSW        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SIDS-1:0] req,
  output logic                filter_start,
  output logic [SW-1:0]       filter_sid,
  output logic [FSW-1:0]      filter_stage,
  output logic                filter_wb,
  output logic [SW-1:0]       wb_sid
);

  localparam logic [FSW-1:0] LAST_STAGE = FSW'(FILTER_LAT - 1);

  filt_state_t          state, state_nx;
  logic [NUM_SIDS-1:0]  pending, pending_nx, want;
  logic [MAX_SIDS-1:0]  want_w;
  sched_sid_t           pick;
  logic                 launch;
  logic                 start_nx, wb_nx;
  logic [SW-1:0]        fsid_nx, wbsid_nx;
  logic [FSW-1:0]       stage_nx;

  // State, pending mask and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= F_IDLE;
      pending      <= '0;
      filter_start <= 1'b0;
      filter_sid   <= '0;
      filter_stage <= '0;
      filter_wb    <= 1'b0;
      wb_sid       <= '0;
    end else begin
      state        <= state_nx;
      pending      <= pending_nx;
      filter_start <= start_nx;
      filter_sid   <= fsid_nx;
      filter_stage <= stage_nx;
      filter_wb    <= wb_nx;
      wb_sid       <= wbsid_nx;
    end
  end

  // Next state: a request arriving this cycle is seen alongside stored ones,
  // so a pass can launch the cycle after the request and back-to-back at wb.
  always_comb begin
    want       = pending | req;
    want_w     = '0;
    want_w[NUM_SIDS-1:0] = want;
    pick       = lowest_set(want_w);
    state_nx   = state;
    pending_nx = want;
    launch     = 1'b0;
    start_nx   = 1'b0;
    wb_nx      = 1'b0;
    fsid_nx    = filter_sid;
    wbsid_nx   = wb_sid;
    stage_nx   = '0;
    case (state)
      F_IDLE: launch = |want;
      F_RUN: begin
        if (filter_stage == LAST_STAGE) begin
          wb_nx    = 1'b1;
          wbsid_nx = filter_sid;
          launch   = |want;
          if (!launch) state_nx = F_IDLE;
        end else begin
          stage_nx = filter_stage + 1'b1;
        end
      end
      default: state_nx = F_IDLE;
    endcase
    if (launch) begin
      start_nx   = 1'b1;
      fsid_nx    = pick[SW-1:0];
      pending_nx = want & ~(NUM_SIDS'(1) << pick);
      state_nx   = F_RUN;
    end
  end

endmodule

// File: rtl/sid_pipe_sched.sv
// Per-SID-cycle scheduler for the shared sid_voice / sid_filter pipelines.
module sid_pipe_sched
  import sid_pipe_sched_pkg::*;
#(
  parameter int unsigned NUM_SIDS   = 2,
  parameter int unsigned VOICE_LAT  = VOICE_LAT_DEFAULT,
  parameter int unsigned FILTER_LAT = FILTER_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  sid_pipe_sched_if.master bus
);

  localparam int unsigned SW  = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1;
  localparam int unsigned FSW = $clog2(FILTER_LAT);
  localparam logic [SW-1:0] LAST_SID = SW'(NUM_SIDS - 1);

  logic accept;
  assign accept = bus.start && !bus.busy;

  // Start acceptance, busy window and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (accept)               bus.busy <= 1'b1;
      else if (bus.audio_valid) bus.busy <= 1'b0;
      if (bus.start && bus.busy) bus.overrun <= 1'b1;
      else if (bus.clr_overrun)  bus.overrun <= 1'b0;
    end
  end

  // Voice slot issue, SID-major, one slot per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.voice_issue <= 1'b0;
      bus.voice_sid   <= '0;
      bus.voice_no    <= '0;
    end else if (accept) begin
      bus.voice_issue <= 1'b1;
      bus.voice_sid   <= '0;
      bus.voice_no    <= '0;
    end else if (bus.voice_issue) begin
      if (bus.voice_no == 2'd2) begin
        bus.voice_no <= '0;
        if (bus.voice_sid == LAST_SID) begin
          bus.voice_issue <= 1'b0;
          bus.voice_sid   <= '0;
        end else begin
          bus.voice_sid <= bus.voice_sid + 1'b1;
        end
      end else begin
        bus.voice_no <= bus.voice_no + 1'b1;
      end
    end
  end

  logic [VOICE_LAT-1:0]         dl_v, pre_v;
  logic [VOICE_LAT-1:0][SW-1:0] dl_sid, pre_sid;
  logic [VOICE_LAT-1:0][1:0]    dl_no, pre_no;

  // Input to each delay stage; the last one also feeds the osc3 decode so
  // osc3_we lands in the same cycle as the matching vout.
  always_comb begin
    pre_v   = '0;
    pre_sid = '0;
    pre_no  = '0;
    pre_v[0]   = bus.voice_issue;
    pre_sid[0] = bus.voice_sid;
    pre_no[0]  = bus.voice_no;
    for (int unsigned j = 1; j < VOICE_LAT; j++) begin
      pre_v[j]   = dl_v[j-1];
      pre_sid[j] = dl_sid[j-1];
      pre_no[j]  = dl_no[j-1];
    end
  end

  // Voice output delay line and OSC3 latch strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v        <= '0;
      dl_sid      <= '0;
      dl_no       <= '0;
      bus.osc3_we <= '0;
    end else begin
      dl_v        <= pre_v;
      dl_sid      <= pre_sid;
      dl_no       <= pre_no;
      bus.osc3_we <= (pre_v[VOICE_LAT-1] && pre_no[VOICE_LAT-1] == 2'd2)
                     ? (NUM_SIDS'(1) << pre_sid[VOICE_LAT-1]) : '0;
    end
  end

  assign bus.vout_valid = dl_v[VOICE_LAT-1];
  assign bus.vout_sid   = dl_sid[VOICE_LAT-1];
  assign bus.vout_no    = dl_no[VOICE_LAT-1];

  // Audio sample complete once the last SID's filter pass is written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.audio_valid <= 1'b0;
    else     bus.audio_valid <= bus.filter_wb && (bus.wb_sid == LAST_SID);
  end

  sid_filter_seq #(
    .NUM_SIDS  (NUM_SIDS),
    .FILTER_LAT(FILTER_LAT),
    .SW        (SW),
    .FSW       (FSW)
  ) u_filter_seq (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.osc3_we),
    .filter_start(bus.filter_start),
    .filter_sid  (bus.filter_sid),
    .filter_stage(bus.filter_stage),
    .filter_wb   (bus.filter_wb),
    .wb_sid      (bus.wb_sid)
  );

endmodule
